// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory load/store path: access sizes,
// LSU states, big-endian lane offsets and the alignment check helper.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  // Big-endian: offset 0 is the most significant byte of the word.
  localparam logic [1:0] OFF_B0 = 2'd0;
  localparam logic [1:0] OFF_B1 = 2'd1;
  localparam logic [1:0] OFF_B2 = 2'd2;
  localparam logic [1:0] OFF_B3 = 2'd3;
  localparam logic       OFF_H0 = 1'b0;
  localparam logic       OFF_H1 = 1'b1;

  // Size 11 is an alias of word, so bit 1 alone marks a full-word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic m;
    if (is_word(size)) begin
      m = (off != 2'b00);
    end else if (size == SZ_HALF) begin
      m = off[0];
    end else begin
      m = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/mips_lsu_lane.sv
// Combinational lane logic: extracts and extends the addressed byte/halfword
// for loads, and merges store data into the old word for sub-word stores.
module mips_lsu_lane
  import mips_mem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_ld_data,
  output logic [31:0] o_st_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and halfword lanes out of the memory word.
  always_comb begin
    w_byte = 8'd0;
    w_half = 16'd0;
    case (i_off)
      OFF_B0:  w_byte = i_old[31:24];
      OFF_B1:  w_byte = i_old[23:16];
      OFF_B2:  w_byte = i_old[15:8];
      OFF_B3:  w_byte = i_old[7:0];
      default: w_byte = 8'd0;
    endcase
    if (i_off[1] == OFF_H1) begin
      w_half = i_old[15:0];
    end else begin
      w_half = i_old[31:16];
    end
  end

  // Extend the selected lane for loads; splice store data into the old word.
  always_comb begin
    o_ld_data = i_old;
    o_st_word = i_old;
    case (i_size)
      SZ_BYTE: begin
        if (i_signed) begin
          o_ld_data = {{24{w_byte[7]}}, w_byte};
        end else begin
          o_ld_data = {24'd0, w_byte};
        end
        case (i_off)
          OFF_B0:  o_st_word[31:24] = i_wdata[7:0];
          OFF_B1:  o_st_word[23:16] = i_wdata[7:0];
          OFF_B2:  o_st_word[15:8]  = i_wdata[7:0];
          OFF_B3:  o_st_word[7:0]   = i_wdata[7:0];
          default: o_st_word        = i_old;
        endcase
      end
      SZ_HALF: begin
        if (i_signed) begin
          o_ld_data = {{16{w_half[15]}}, w_half};
        end else begin
          o_ld_data = {16'd0, w_half};
        end
        if (i_off[1] == OFF_H0) begin
          o_st_word[31:16] = i_wdata[15:0];
        end else begin
          o_st_word[15:0] = i_wdata[15:0];
        end
      end
      default: begin
        o_ld_data = i_old;
        o_st_word = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit driving a word-wide data memory, with read-modify-write
// for sub-word stores. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module mips_lsu
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [31:0]       r_mem_wdata;
  logic              r_resp_valid;
  logic [31:0]       r_resp_rdata;
  logic              r_resp_err;
  logic              w_accept;
  logic              w_misal;
  logic [31:0]       w_ld_data;
  logic [31:0]       w_st_word;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misal = misaligned(req_size, req_addr[1:0]);
`else
  assign w_misal = 1'b0;
`endif

  assign w_accept   = req_valid && (r_state == ST_IDLE);
  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;
  assign mem_wdata  = r_mem_wdata;

  mips_lsu_lane u_lane (
    .i_off     (r_off),
    .i_size    (r_size),
    .i_signed  (r_signed),
    .i_old     (mem_rdata),
    .i_wdata   (r_wdata),
    .o_ld_data (w_ld_data),
    .o_st_word (w_st_word)
  );

  // Next-state decode; only full-word stores skip the read phase.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_misal) begin
            w_next = ST_RESP;
          end else if (req_write && is_word(req_size)) begin
            w_next = ST_WR;
          end else begin
            w_next = ST_RD;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_RD: begin
        if (r_write) begin
          w_next = ST_WR;
        end else begin
          w_next = ST_RESP;
        end
      end
      ST_WR:   w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // State, strobes and response registers; strobes are decoded from next state
  // so they are registered yet aligned with the RD/WR cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_write      <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_off        <= 2'd0;
      r_wdata      <= 32'd0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_wdata  <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_mem_rd     <= (w_next == ST_RD);
      r_mem_wr     <= (w_next == ST_WR);
      r_resp_valid <= (w_next == ST_RESP);
      if (w_accept) begin
        r_write      <= req_write;
        r_size       <= req_size;
        r_signed     <= req_signed;
        r_off        <= req_addr[1:0];
        r_wdata      <= req_wdata;
        r_mem_addr   <= req_addr[ADDR_W+1:2];
        r_resp_rdata <= 32'd0;
        r_resp_err   <= w_misal;
        if (req_write && is_word(req_size) && !w_misal) begin
          r_mem_wdata <= req_wdata;
        end else begin
          r_mem_wdata <= r_mem_wdata;
        end
      end else if (r_state == ST_RD) begin
        if (r_write) begin
          r_mem_wdata <= w_st_word;
        end else begin
          r_resp_rdata <= w_ld_data;
        end
      end else begin
        r_mem_wdata <= r_mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: word-level memory model plus a
// transaction-level reference that predicts every response.
module tb_mips_lsu;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mips_lsu #(.ADDR_W(8)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] dmem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = 8'd0;
  logic [31:0] poke_data = 32'd0;

  assign mem_rdata = dmem[mem_addr];

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (mem_wr) dmem[mem_addr] <= mem_wdata;
    else if (poke_en) dmem[poke_addr] <= poke_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic mis_model(input logic [1:0] sz, input logic [1:0] off);
    logic m;
    if (sz == 2'd1) m = off[0];
    else if (sz >= 2'd2) m = (off != 2'd0);
    else m = 1'b0;
    return TRAP && m;
  endfunction

  // Reference state for the single outstanding transaction
  logic        outstanding = 1'b0;
  int          e_cyc, rd_cnt, wr_cnt, acc_cnt = 0, resp_cnt = 0;
  logic [31:0] e_rdata, st_val;
  logic        e_err, st_commit, e_rd, e_wr;
  logic [7:0]  e_word;
  int          nb, sh, offi;
  logic [31:0] mask, old, fld;

  always @(negedge CLK) begin
    if (RST) begin
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
      chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      outstanding = 1'b0;
    end else begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !outstanding});
      chk("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
      if (!outstanding) chk("idle_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
      else begin
        if (mem_rd) begin rd_cnt++; chk("rd_addr", {24'd0, mem_addr}, {24'd0, e_word}); end
        if (mem_wr) begin
          wr_cnt++;
          chk("wr_addr", {24'd0, mem_addr}, {24'd0, e_word});
          chk("wr_data", mem_wdata, st_val);
        end
      end
      if (resp_valid) begin
        if (!outstanding) chk("resp_spurious", {31'd0, resp_valid}, 32'd0);
        else begin
          chk("resp_latency", cyc, e_cyc);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e_err});
          if (!e_err) chk("resp_rdata", resp_rdata, e_rdata);
          chk("rd_count", rd_cnt, {31'd0, e_rd});
          chk("wr_count", wr_cnt, {31'd0, e_wr});
          if (st_commit) ref_mem[e_word] = st_val;
          outstanding = 1'b0;
          resp_cnt++;
        end
      end else if (outstanding && cyc >= e_cyc) begin
        chk("resp_missing", {31'd0, resp_valid}, 32'd1);
        outstanding = 1'b0;
      end
      if (req_valid && req_ready) begin
        offi   = int'(req_addr[1:0]);
        nb     = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
        e_err  = mis_model(req_size, req_addr[1:0]);
        e_word = req_addr[9:2];
        old    = ref_mem[e_word];
        mask   = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        sh     = (nb == 1) ? 8 * (3 - offi) : (nb == 2) ? 8 * (2 - (offi / 2) * 2) : 0;
        fld    = (old >> sh) & mask;
        if (req_signed && nb < 4 && fld[8 * nb - 1]) fld = fld | ~mask;
        e_rdata   = req_write ? 32'd0 : fld;
        st_val    = (old & ~(mask << sh)) | ((req_wdata & mask) << sh);
        st_commit = req_write && !e_err;
        e_rd      = !e_err && (!req_write || nb < 4);
        e_wr      = !e_err && req_write;
        e_cyc     = cyc + (e_err ? 1 : (req_write && nb < 4) ? 3 : 2);
        rd_cnt = 0;
        wr_cnt = 0;
        outstanding = 1'b1;
        acc_cnt++;
      end
    end
    if (poke_en) ref_mem[poke_addr] = poke_data;
  end

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    @(posedge CLK); #1;
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge CLK); #1;
    poke_en = 1'b0;
  endtask

  task automatic xfer(input logic w, input logic [1:0] sz, input logic sg, input logic [9:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    logic got;
    int acc_c;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    got = 1'b0; acc_c = 0; rd = 32'd0; er = 1'b0; lat = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (req_ready) begin got = 1'b1; acc_c = cyc; break; end
    end
    chk("accept_timeout", {31'd0, got}, 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (resp_valid) begin got = 1'b1; rd = resp_rdata; er = resp_err; lat = cyc - acc_c; break; end
    end
    chk("resp_timeout", {31'd0, got}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, a0, r0;
  logic        seen;

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 10'd0; req_wdata = 32'd0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 16; i++) poke(8'(i), $urandom);

    // Word store then word load
    xfer(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", lat, 32'd2);
    chk("sw_rdata", rd, 32'd0);
    xfer(1'b0, 2'd2, 1'b0, 10'h010, 32'd0, rd, er, lat);
    chk("lw_lat", lat, 32'd2);
    chk("lw_rdata", rd, 32'hDEADBEEF);

    // Sub-word store RMW
    poke(8'd4, 32'h11223344);
    xfer(1'b1, 2'd0, 1'b0, 10'h012, 32'h000000AA, rd, er, lat);
    chk("sb_lat", lat, 32'd3);
    chk("sb_mem", dmem[4], 32'h1122AA44);

    // Sign/zero extension
    poke(8'd4, 32'h80FF7F01);
    xfer(1'b0, 2'd0, 1'b1, 10'h011, 32'd0, rd, er, lat);
    chk("lb_rdata", rd, 32'hFFFFFFFF);
    chk("lb_lat", lat, 32'd2);
    xfer(1'b0, 2'd0, 1'b0, 10'h011, 32'd0, rd, er, lat);
    chk("lbu_rdata", rd, 32'h000000FF);
    xfer(1'b0, 2'd1, 1'b1, 10'h010, 32'd0, rd, er, lat);
    chk("lh_rdata", rd, 32'hFFFF80FF);
    xfer(1'b0, 2'd1, 1'b0, 10'h012, 32'd0, rd, er, lat);
    chk("lhu_rdata", rd, 32'h00007F01);

    // Misaligned word load
    xfer(1'b0, 2'd2, 1'b0, 10'h013, 32'd0, rd, er, lat);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_err", {31'd0, er}, 32'd1);
    chk("mis_lat", lat, 32'd1);
`else
    chk("mis_rdata", rd, 32'h80FF7F01);
    chk("mis_lat", lat, 32'd2);
`endif
    chk("mis_mem", dmem[4], 32'h80FF7F01);

    // Reset during the read phase of a halfword RMW
    poke(8'd8, 32'hCAFEF00D);
    r0 = resp_cnt;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 10'h020; req_wdata = 32'h00001234;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge CLK);
      if (req_ready) begin seen = 1'b1; break; end
    end
    chk("rst_accept", {31'd0, seen}, 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    chk("rst_in_rd", {31'd0, mem_rd}, 32'd1);
    RST = 1'b1;
    #1 chk("rst_async_rd", {31'd0, mem_rd}, 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    chk("rst_mem8", dmem[8], 32'hCAFEF00D);
    chk("rst_ready_after", {31'd0, req_ready}, 32'd1);
    chk("rst_no_resp", resp_cnt, r0);

    // Alternating SW/LW with req_valid held high
    a0 = acc_cnt; r0 = resp_cnt;
    @(posedge CLK); #1;
    for (int i = 0; i < 16; i++) begin
      int prev;
      req_valid = 1'b1;
      req_write = (i % 2 == 0);
      req_size = 2'd2;
      req_signed = 1'b0;
      if (i % 2 == 0) begin
        req_addr = {4'd0, 4'($urandom_range(0, 15)), 2'd0};
        req_wdata = $urandom;
      end
      prev = acc_cnt;
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(posedge CLK);
        if (acc_cnt != prev) begin seen = 1'b1; break; end
      end
      chk("hold_accept", {31'd0, seen}, 32'd1);
      #1;
    end
    req_valid = 1'b0;
    repeat (8) @(posedge CLK);
    chk("hold_accepts", acc_cnt - a0, 32'd16);
    chk("hold_resps", resp_cnt - r0, 32'd16);

    // Randomised traffic
    for (int i = 0; i < 200; i++) begin
      xfer(1'($urandom), 2'($urandom), 1'($urandom), 10'($urandom_range(0, 63)), $urandom, rd, er, lat);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge CLK);
    end
    repeat (6) @(posedge CLK);
    for (int i = 0; i < 16; i++) chk("final_mem", dmem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_lsu.md
# mips_lsu

Load/store unit for the MIPS datapath: the initiator side of the data memory port. Accepts one byte, halfword or word access per request from the MEM stage, drives the word-wide data memory's address/read/write strobes, performs read-modify-write for sub-word stores, and returns sign- or zero-extended load data. It sits between the MEM-stage control logic and the 256-word data memory.

## Interface
- ADDR_W, 8, word-address width of the data memory (256 words)
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word
- req_signed  in  1  loads only: sign-extend (LB/LH) vs zero-extend (LBU/LHU)
- req_addr  in  ADDR_W+2  byte address; [1:0] byte offset, [ADDR_W+1:2] word index
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misaligned access (valid with resp_valid)
- mem_addr  out  ADDR_W  word address to data memory
- mem_rd  out  1  read strobe
- mem_wr  out  1  write strobe (memory writes on rising CLK)
- mem_wdata  out  32  word to write
- mem_rdata  in  32  combinational read data from memory

## Operation
- Big-endian lanes: offset 0 = bits [31:24], offset 3 = bits [7:0]; halfword offset 0 = [31:16], offset 2 = [15:0].
- States: IDLE, RD, WR, RESP. Accept = req_valid && req_ready; request fields latched on accept.
- Load: IDLE -> RD -> RESP. In RD, mem_rd=1, mem_addr=latched word; selected lane extracted, extended, registered.
- Word store: IDLE -> WR -> RESP. In WR, mem_wr=1, mem_wdata=req_wdata.
- Sub-word store: IDLE -> RD -> WR -> RESP. RD captures the old word; WR writes old word with target lane(s) replaced by low byte/halfword of req_wdata.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No response backpressure.
- Misalignment (see Configuration): halfword with addr[0]=1, word with addr[1:0]!=0 -> IDLE -> RESP with resp_err=1, no mem_rd/mem_wr asserted.
- mem_rd and mem_wr never both high; both low outside RD/WR.

## Timing
- Reset values: req_ready=1 (state IDLE), resp_valid=0, resp_rdata=0, resp_err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- Latency accept -> resp_valid: load 2 cycles, word store 2, sub-word store 3, misaligned 1.
- req_ready low from cycle after accept until state returns to IDLE; request held high during that time is ignored, not queued.
- Back-to-back: new request accepted the cycle after resp_valid.
- Store data visible to a following load: write completes at WR's closing edge, before any later RD.
- RST mid-operation: immediate return to IDLE, mem_wr/mem_rd drop asynchronously; an aborted sub-word RMW performs no write; no response is issued.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned requests detected, suppressed, reported via resp_err.
- Not defined: offset bits below access size ignored (halfword uses addr[1], word uses addr[1:0]=0); access proceeds normally; resp_err tied 0.

## Structure
- Package mips_mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, LSU state enum, lane-select constants.
- One sub-module: mips_lsu_lane — combinational lane extract/extend (load) and lane merge (store) from offset and size.

## Test plan
- Word store 0xDEADBEEF to byte addr 0x010, then word load 0x010 -> resp_rdata=0xDEADBEEF; latencies 2 and 2.
- Mem word 4 = 0x11223344; SB 0xAA at 0x012 -> word becomes 0x1122AA44, 3-cycle latency, one mem_rd then one mem_wr.
- Word 4 = 0x80FF7F01; LB 0x011 signed -> 0xFFFFFFFF; LBU 0x011 -> 0x000000FF; LH 0x010 signed -> 0xFFFF80FF; LHU 0x012 -> 0x00007F01.
- With LSU_MISALIGN_TRAP_EN: LW at 0x013 -> resp_err=1 after 1 cycle, no strobes, memory unchanged; without macro: returns word 4.
- Assert RST during RD of SH to 0x020 -> word 8 unchanged, req_ready=1, no resp_valid.
- req_valid held high continuously for alternating SW/LW -> one accept per completion, no lost or duplicated accesses.
